// File: rtl/regfile_pkg.sv
// Shared constants for the scoreboarded register file.
// Register-index constants are plain ints; users cast to their index width.
package regfile_pkg;

  localparam int DEF_DATA_W   = 32;
  localparam int DEF_NUM_REGS = 32;
  localparam int DEF_NUM_RD   = 2;

  localparam int REG_ZERO = 0;
  localparam int REG_V0   = 2;

endpackage

// File: rtl/regfile_sb_scoreboard.sv
// Busy-bit tracker for in-flight loads.
// A set beats a clear on the same register; register 0 is never busy.
module regfile_sb_scoreboard
  import regfile_pkg::*;
#(
  parameter int NUM_REGS = DEF_NUM_REGS,
  localparam int AW = $clog2(NUM_REGS)
) (
  input  logic                r_clk,
  input  logic                reset,
  input  logic                r_clk_enable,
  input  logic                sb_set,
  input  logic [AW-1:0]       sb_reg,
  input  logic                wb_en,
  input  logic [AW-1:0]       wb_reg,
  output logic [NUM_REGS-1:0] busy,
  output logic                busy_any
);

  logic [NUM_REGS-1:0] r_busy;
  logic                r_busy_any;
  logic [NUM_REGS-1:0] w_busy_nxt;

  always_comb begin
    w_busy_nxt = r_busy;
    if (wb_en)
      w_busy_nxt[wb_reg] = 1'b0;
    if (sb_set)
      w_busy_nxt[sb_reg] = 1'b1;
    w_busy_nxt[REG_ZERO] = 1'b0;
  end

  always_ff @(posedge r_clk) begin
    if (reset) begin
      r_busy     <= '0;
      r_busy_any <= 1'b0;
    end else if (r_clk_enable) begin
      r_busy     <= w_busy_nxt;
      r_busy_any <= |w_busy_nxt;
    end
  end

  assign busy     = r_busy;
  assign busy_any = r_busy_any;

endmodule

// File: rtl/regfile_sb.sv
// Multi-read, two-write register file with load scoreboard.
// Define REGFILE_SB_BYPASS_EN for same-cycle write-to-read forwarding.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int NUM_RD   = DEF_NUM_RD,
  localparam int AW = $clog2(NUM_REGS)
) (
  input  logic                     r_clk,
  input  logic                     reset,
  input  logic                     r_clk_enable,
  input  logic                     wa_en,
  input  logic [AW-1:0]            wa_reg,
  input  logic [DATA_W-1:0]        wa_data,
  input  logic                     wb_en,
  input  logic [AW-1:0]            wb_reg,
  input  logic [DATA_W-1:0]        wb_data,
  input  logic                     sb_set,
  input  logic [AW-1:0]            sb_reg,
  input  logic [NUM_RD*AW-1:0]     rd_reg,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  output logic                     busy_any,
  output logic [DATA_W-1:0]        regfile_v0
);

  localparam logic [AW-1:0] ZERO_IDX = AW'(REG_ZERO);

  logic [DATA_W-1:0]   r_regs [NUM_REGS];
  logic [NUM_REGS-1:0] w_busy;

  regfile_sb_scoreboard #(
    .NUM_REGS(NUM_REGS)
  ) u_sb (
    .r_clk       (r_clk),
    .reset       (reset),
    .r_clk_enable(r_clk_enable),
    .sb_set      (sb_set),
    .sb_reg      (sb_reg),
    .wb_en       (wb_en),
    .wb_reg      (wb_reg),
    .busy        (w_busy),
    .busy_any    (busy_any)
  );

  // Port A is written last so it wins a same-register collision.
  always_ff @(posedge r_clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++)
        r_regs[i] <= '0;
    end else if (r_clk_enable) begin
      if (wb_en && wb_reg != ZERO_IDX)
        r_regs[wb_reg] <= wb_data;
      if (wa_en && wa_reg != ZERO_IDX)
        r_regs[wa_reg] <= wa_data;
    end
  end

  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    logic [AW-1:0]     w_idx;
    logic [DATA_W-1:0] w_data;
    logic              w_bsy;

    assign w_idx = rd_reg[g*AW +: AW];

    always_comb begin
      w_data = r_regs[w_idx];
      w_bsy  = w_busy[w_idx];
`ifdef REGFILE_SB_BYPASS_EN
      if (r_clk_enable && !reset) begin
        if (wa_en && wa_reg == w_idx)
          w_data = wa_data;
        else if (wb_en && wb_reg == w_idx)
          w_data = wb_data;
        if (wb_en && wb_reg == w_idx)
          w_bsy = 1'b0;
        if (sb_set && sb_reg == w_idx)
          w_bsy = 1'b1;
      end
`endif
      if (w_idx == ZERO_IDX) begin
        w_data = '0;
        w_bsy  = 1'b0;
      end
    end

    assign rd_data[g*DATA_W +: DATA_W] = w_data;
    assign rd_busy[g]                  = w_bsy;
  end

  if (NUM_REGS > REG_V0) begin : g_v0
    assign regfile_v0 = r_regs[AW'(REG_V0)];
  end else begin : g_no_v0
    assign regfile_v0 = '0;
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb: stimulus pushes expectations,
// a negedge monitor pops and compares them.
module tb_regfile_sb;

  logic        r_clk = 1'b0;
  logic        reset;
  logic        r_clk_enable;
  logic        wa_en;
  logic [4:0]  wa_reg;
  logic [31:0] wa_data;
  logic        wb_en;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic        sb_set;
  logic [4:0]  sb_reg;
  logic [9:0]  rd_reg;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic        busy_any;
  logic [31:0] regfile_v0;

  always #5 r_clk = ~r_clk;

  regfile_sb dut (
    .r_clk       (r_clk),
    .reset       (reset),
    .r_clk_enable(r_clk_enable),
    .wa_en       (wa_en),
    .wa_reg      (wa_reg),
    .wa_data     (wa_data),
    .wb_en       (wb_en),
    .wb_reg      (wb_reg),
    .wb_data     (wb_data),
    .sb_set      (sb_set),
    .sb_reg      (sb_reg),
    .rd_reg      (rd_reg),
    .rd_data     (rd_data),
    .rd_busy     (rd_busy),
    .busy_any    (busy_any),
    .regfile_v0  (regfile_v0)
  );

  typedef struct {
    logic [31:0] d0;
    logic [31:0] d1;
    logic [1:0]  b;
    logic        any;
    logic [31:0] v0;
    int          tag;
  } exp_t;

  exp_t q[$];
  logic mon_en = 1'b0;
  int   n_cmp  = 0;
  int   n_bad  = 0;
  int   tag    = 0;

  function automatic void chk(string nm, int t,
                              logic [31:0] got, logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s#%0d got %h want %h", nm, t, got, want);
    end
  endfunction

  always @(negedge r_clk) begin
    if (mon_en) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL underflow got empty want entry");
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("rd0", e.tag, rd_data[31:0], e.d0);
        chk("rd1", e.tag, rd_data[63:32], e.d1);
        chk("busy", e.tag, {30'd0, rd_busy}, {30'd0, e.b});
        chk("any", e.tag, {31'd0, busy_any}, {31'd0, e.any});
        chk("v0", e.tag, regfile_v0, e.v0);
      end
    end
  end

  task automatic idle();
    reset   = 1'b0;
    r_clk_enable = 1'b1;
    wa_en   = 1'b0; wa_reg = '0; wa_data = '0;
    wb_en   = 1'b0; wb_reg = '0; wb_data = '0;
    sb_set  = 1'b0; sb_reg = '0;
  endtask

  task automatic rd(input logic [4:0] p0, input logic [4:0] p1);
    rd_reg = {p1, p0};
  endtask

  task automatic expect_rd(input logic [31:0] d0, input logic [31:0] d1,
                           input logic [1:0] b, input logic any,
                           input logic [31:0] v0);
    exp_t e;
    e.d0 = d0; e.d1 = d1; e.b = b; e.any = any; e.v0 = v0;
    e.tag = tag++;
    q.push_back(e);
    mon_en = 1'b1;
  endtask

  task automatic tick();
    @(posedge r_clk);
    #1;
    mon_en = 1'b0;
    idle();
  endtask

  initial begin
    idle();
    rd(5'd0, 5'd0);
    @(posedge r_clk); #1;
    reset = 1'b1;
    wa_en = 1'b1; wa_reg = 5'd7; wa_data = 32'h1;
    tick();

    // every register reads zero after reset
    for (int i = 0; i < 32; i++) begin
      rd(5'(i), 5'(31 - i));
      expect_rd(32'h0, 32'h0, 2'b00, 1'b0, 32'h0);
      tick();
    end

    // port A beats port B on the same register
    wa_en = 1'b1; wa_reg = 5'd5; wa_data = 32'hDEADBEEF;
    wb_en = 1'b1; wb_reg = 5'd5; wb_data = 32'h12345678;
    tick();
    rd(5'd5, 5'd0);
    expect_rd(32'hDEADBEEF, 32'h0, 2'b00, 1'b0, 32'h0);
    tick();

    // register 0 ignores writes and busy
    wa_en = 1'b1; wa_reg = 5'd0; wa_data = 32'hFFFFFFFF;
    sb_set = 1'b1; sb_reg = 5'd0;
    tick();
    rd(5'd0, 5'd0);
    expect_rd(32'h0, 32'h0, 2'b00, 1'b0, 32'h0);
    tick();

    // set wins over clear on the same register
    sb_set = 1'b1; sb_reg = 5'd8;
    tick();
    rd(5'd8, 5'd5);
    expect_rd(32'h0, 32'hDEADBEEF, 2'b01, 1'b1, 32'h0);
    tick();
    sb_set = 1'b1; sb_reg = 5'd8;
    wb_en = 1'b1; wb_reg = 5'd8; wb_data = 32'hA5;
    tick();
    rd(5'd8, 5'd0);
    expect_rd(32'hA5, 32'h0, 2'b01, 1'b1, 32'h0);
    tick();
    wb_en = 1'b1; wb_reg = 5'd8; wb_data = 32'hA5;
    tick();
    rd(5'd8, 5'd0);
    expect_rd(32'hA5, 32'h0, 2'b00, 1'b0, 32'h0);
    tick();

    // same-cycle read of register 2 during its write
    wa_en = 1'b1; wa_reg = 5'd2; wa_data = 32'h55;
    rd(5'd2, 5'd5);
`ifdef REGFILE_SB_BYPASS_EN
    expect_rd(32'h55, 32'hDEADBEEF, 2'b00, 1'b0, 32'h0);
`else
    expect_rd(32'h0, 32'hDEADBEEF, 2'b00, 1'b0, 32'h0);
`endif
    tick();
    rd(5'd2, 5'd0);
    expect_rd(32'h55, 32'h0, 2'b00, 1'b0, 32'h55);
    tick();

    // clock enable low freezes data and busy
    r_clk_enable = 1'b0;
    wa_en = 1'b1; wa_reg = 5'd3; wa_data = 32'h7;
    sb_set = 1'b1; sb_reg = 5'd4;
    rd(5'd3, 5'd4);
    expect_rd(32'h0, 32'h0, 2'b00, 1'b0, 32'h55);
    tick();
    rd(5'd3, 5'd4);
    expect_rd(32'h0, 32'h0, 2'b00, 1'b0, 32'h55);
    tick();

    // port A write to busy register keeps it busy
    sb_set = 1'b1; sb_reg = 5'd9;
    tick();
    wa_en = 1'b1; wa_reg = 5'd9; wa_data = 32'h11;
    tick();
    rd(5'd9, 5'd2);
    expect_rd(32'h11, 32'h55, 2'b01, 1'b1, 32'h55);
    tick();

    // reset discards in-flight loads, overriding writes
    reset = 1'b1;
    wa_en = 1'b1; wa_reg = 5'd2; wa_data = 32'h99;
    sb_set = 1'b1; sb_reg = 5'd6;
    tick();
    rd(5'd9, 5'd2);
    expect_rd(32'h0, 32'h0, 2'b00, 1'b0, 32'h0);
    tick();
    rd(5'd6, 5'd6);
    expect_rd(32'h0, 32'h0, 2'b00, 1'b0, 32'h0);
    tick();
    wb_en = 1'b1; wb_reg = 5'd9; wb_data = 32'h22;
    tick();
    rd(5'd9, 5'd0);
    expect_rd(32'h22, 32'h0, 2'b00, 1'b0, 32'h0);
    tick();

    // load return on a busy register read in the same cycle
    sb_set = 1'b1; sb_reg = 5'd10;
    tick();
    wb_en = 1'b1; wb_reg = 5'd10; wb_data = 32'h33;
    rd(5'd10, 5'd9);
`ifdef REGFILE_SB_BYPASS_EN
    expect_rd(32'h33, 32'h22, 2'b00, 1'b1, 32'h0);
`else
    expect_rd(32'h0, 32'h22, 2'b01, 1'b1, 32'h0);
`endif
    tick();
    rd(5'd10, 5'd9);
    expect_rd(32'h33, 32'h22, 2'b00, 1'b0, 32'h0);
    tick();

    // both write ports and a set to one register, read same cycle
    wa_en = 1'b1; wa_reg = 5'd11; wa_data = 32'hAAAA;
    wb_en = 1'b1; wb_reg = 5'd11; wb_data = 32'hBBBB;
    sb_set = 1'b1; sb_reg = 5'd11;
    rd(5'd0, 5'd11);
`ifdef REGFILE_SB_BYPASS_EN
    expect_rd(32'h0, 32'hAAAA, 2'b10, 1'b0, 32'h0);
`else
    expect_rd(32'h0, 32'h0, 2'b00, 1'b0, 32'h0);
`endif
    tick();
    rd(5'd0, 5'd11);
    expect_rd(32'h0, 32'hAAAA, 2'b10, 1'b1, 32'h0);
    tick();

    @(negedge r_clk);
    if (q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL leftover got %0d want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
